polyphase_halfband_interp: RTL and testbench

POLYPHASE_HALFBAND_INTERP -- requirements
Module: polyphase_halfband_interp

---
 rtl/polyphase_pkg.sv | 32 +++
 rtl/hb_interp_mac.sv | 65 ++++++
 rtl/polyphase_halfband_interp.sv | 110 +++++++++++
 tb/tb_polyphase_halfband_interp.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/polyphase_pkg.sv
// Shared constants, coefficient table and FSM state type for the 2x half-band interpolator.
// Sample width default, branch-A taps (Q1.15, x2 interpolation gain) and accumulator sizing.
package polyphase_pkg;

   localparam int SAMPLE_WIDTH_DEF = 16;
   localparam int N_DEF            = 31;
   localparam int PHASE_TAPS_DEF   = (N_DEF + 1) / 2;
   localparam int COEF_WIDTH       = 16;
   localparam int FRAC_BITS        = 15;

   typedef logic signed [COEF_WIDTH-1:0] coef_t;

   // Even-index prototype taps doubled; symmetric, sum = 32768.
   localparam coef_t CA [PHASE_TAPS_DEF] = '{
      -16'sd80,   16'sd180,  -16'sd400,   16'sd800,
      -16'sd1600, 16'sd3000, -16'sd6000,  16'sd20484,
       16'sd20484, -16'sd6000, 16'sd3000, -16'sd1600,
       16'sd800,  -16'sd400,  16'sd180,  -16'sd80
   };

   function automatic int acc_width(input int sample_w, input int taps);
      return 2 * sample_w + $clog2(taps);
   endfunction

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      OUT_A = 2'd2,
      OUT_B = 2'd3
   } state_e;

endpackage

// File: rtl/hb_interp_mac.sv
// Single-multiplier accumulator for branch A with clear, enable, round-half-up and width reduction.
// Define HB_INTERP_SATURATE_EN to clamp the rounded result instead of wrapping it.
module hb_interp_mac
   import polyphase_pkg::*;
#(
   parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
   parameter int PHASE_TAPS   = PHASE_TAPS_DEF
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           i_clr,
   input  logic                           i_en,
   input  logic signed [SAMPLE_WIDTH-1:0] i_sample,
   input  coef_t                          i_coef,
   output logic signed [SAMPLE_WIDTH-1:0] o_result
);

   localparam int ACC_W  = acc_width(SAMPLE_WIDTH, PHASE_TAPS);
   localparam int PROD_W = SAMPLE_WIDTH + COEF_WIDTH;
   localparam int RND_W  = ACC_W - FRAC_BITS;
   localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1 << (FRAC_BITS - 1));

   logic signed [PROD_W-1:0] w_sample_x;
   logic signed [PROD_W-1:0] w_coef_x;
   logic signed [PROD_W-1:0] w_prod;
   logic signed [ACC_W-1:0]  r_acc;
   logic signed [ACC_W-1:0]  w_rnd_sum;
   logic signed [RND_W-1:0]  w_rnd;
   logic                     w_unused;

   assign w_sample_x = {{(PROD_W-SAMPLE_WIDTH){i_sample[SAMPLE_WIDTH-1]}}, i_sample};
   assign w_coef_x   = {{(PROD_W-COEF_WIDTH){i_coef[COEF_WIDTH-1]}}, i_coef};
   assign w_prod     = w_sample_x * w_coef_x;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc <= '0;
      end else if (i_clr) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= r_acc + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
      end
   end

   // Dropping the low FRAC_BITS of the biased sum is the arithmetic shift.
   assign w_rnd_sum = r_acc + RND_HALF;
   assign w_rnd     = w_rnd_sum[ACC_W-1:FRAC_BITS];

`ifdef HB_INTERP_SATURATE_EN
   logic w_in_range;
   assign w_in_range = (&w_rnd[RND_W-1:SAMPLE_WIDTH-1]) | ~(|w_rnd[RND_W-1:SAMPLE_WIDTH-1]);
   always_comb begin
      o_result = w_rnd[SAMPLE_WIDTH-1:0];
      if (!w_in_range) begin
         o_result = w_rnd[RND_W-1] ? {1'b1, {(SAMPLE_WIDTH-1){1'b0}}}
                                   : {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
      end
   end
   assign w_unused = ^w_rnd_sum[FRAC_BITS-1:0];
`else
   assign o_result = w_rnd[SAMPLE_WIDTH-1:0];
   assign w_unused = ^{w_rnd_sum[FRAC_BITS-1:0], w_rnd[RND_W-1:SAMPLE_WIDTH]};
`endif

endmodule

// File: rtl/polyphase_halfband_interp.sv
// Polyphase half-band 2x interpolator: branch A via serial MAC, branch B a pure delay tap.
// Build option HB_INTERP_SATURATE_EN selects clamping of the branch-A result (see hb_interp_mac).
//
// state | meaning
// IDLE  | waiting for an input sample, ready_in high
// MAC   | one branch-A tap per cycle, PHASE_TAPS cycles
// OUT_A | presenting y[2n] (branch A), waits for ready_out
// OUT_B | presenting y[2n+1] (branch B), waits for ready_out
module polyphase_halfband_interp
   import polyphase_pkg::*;
#(
   parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
   parameter int N            = N_DEF
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           valid_in,
   output logic                           ready_in,
   input  logic signed [SAMPLE_WIDTH-1:0] data_in,
   output logic                           valid_out,
   input  logic                           ready_out,
   output logic signed [SAMPLE_WIDTH-1:0] data_out
);

   localparam int PHASE_TAPS   = (N + 1) / 2;
   localparam int CENTER_DELAY = (N - 3) / 4;
   localparam int CNT_W        = $clog2(PHASE_TAPS);

   state_e                         r_state;
   state_e                         w_state_nxt;
   logic                           r_armed;
   logic [CNT_W-1:0]               r_cnt;
   logic signed [SAMPLE_WIDTH-1:0] r_dline [PHASE_TAPS];
   logic signed [SAMPLE_WIDTH-1:0] w_branch_a;
   logic                           w_accept;

   assign w_accept = valid_in & ready_in;

   // Holds ready_in low until the first edge after reset release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_armed <= 1'b0;
      else          r_armed <= 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      ready_in    = 1'b0;
      valid_out   = 1'b0;
      data_out    = '0;
      case (r_state)
         IDLE: begin
            ready_in = r_armed;
            if (valid_in && r_armed) w_state_nxt = MAC;
         end
         MAC: begin
            if (r_cnt == '0) w_state_nxt = OUT_A;
         end
         OUT_A: begin
            valid_out = 1'b1;
            data_out  = w_branch_a;
            if (ready_out) w_state_nxt = OUT_B;
         end
         OUT_B: begin
            valid_out = 1'b1;
            data_out  = r_dline[CENTER_DELAY];
            if (ready_out) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Tap index runs downward; summation order does not change the result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= CNT_W'(PHASE_TAPS - 1);
      end else if (r_state == MAC && r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < PHASE_TAPS; i++) r_dline[i] <= '0;
      end else if (w_accept) begin
         for (int i = PHASE_TAPS - 1; i > 0; i--) r_dline[i] <= r_dline[i-1];
         r_dline[0] <= data_in;
      end
   end

   hb_interp_mac #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .PHASE_TAPS   (PHASE_TAPS)
   ) u_mac (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_clr    (w_accept),
      .i_en     (r_state == MAC),
      .i_sample (r_dline[r_cnt]),
      .i_coef   (CA[r_cnt]),
      .o_result (w_branch_a)
   );

endmodule

// File: tb/tb_polyphase_halfband_interp.sv
// Directed self-checking bench for polyphase_halfband_interp (default N=31, 16-bit samples).
module tb_polyphase_halfband_interp;

   logic               clk;
   logic               reset_n;
   logic               valid_in;
   logic               ready_in;
   logic signed [15:0] data_in;
   logic               valid_out;
   logic               ready_out;
   logic signed [15:0] data_out;

   int n_checks;
   int n_fails;

   // (16384*cA[k] + 16384) >> 15, worked out by hand for each tap
   int exp_imp [16] = '{-40, 90, -200, 400, -800, 1500, -3000, 10242,
                        10242, -3000, 1500, -800, 400, -200, 90, -40};
   // signs of cA[k]; drives the worst-case overflow pattern
   int tap_sgn [16] = '{-1, 1, -1, 1, -1, 1, -1, 1, 1, -1, 1, -1, 1, -1, 1, -1};

   polyphase_halfband_interp dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .valid_in  (valid_in),
      .ready_in  (ready_in),
      .data_in   (data_in),
      .valid_out (valid_out),
      .ready_out (ready_out),
      .data_out  (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_sample(input int x, input int stall, input int stall_exp,
                            output int ye, output int yo, output int lat);
      int w;
      w = 0;
      while (!ready_in && w < 40) begin @(negedge clk); w++; end
      if (!ready_in) chk("ready_in_wait", int'(ready_in), 1);
      data_in  = 16'(x);
      valid_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid_in = 1'b0;
      lat = 1;
      while (!valid_out && lat < 40) begin @(negedge clk); lat++; end
      if (!valid_out) chk("valid_out_wait", int'(valid_out), 1);
      ye = int'(data_out);
      if (stall > 0) begin
         ready_out = 1'b0;
         for (int i = 0; i < stall; i++) begin
            valid_in = 1'b1;
            data_in  = 16'sd12345;
            @(negedge clk);
            chk("bp_valid", int'(valid_out), 1);
            chk("bp_data", int'(data_out), stall_exp);
            chk("bp_ready_in", int'(ready_in), 0);
         end
         valid_in  = 1'b0;
         ready_out = 1'b1;
      end
      @(negedge clk);
      yo = int'(data_out);
      @(negedge clk);
   endtask

   int ye, yo, lat;
   int x;
   int acc_cnt, out_cnt, last_acc;
   logic a_nxt, h_nxt;

   initial begin
      n_checks  = 0;
      n_fails   = 0;
      reset_n   = 1'b0;
      valid_in  = 1'b0;
      ready_out = 1'b1;
      data_in   = '0;

      // reset state and release
      repeat (3) @(negedge clk);
      chk("rst_valid_out", int'(valid_out), 0);
      chk("rst_data_out", int'(data_out), 0);
      chk("rst_ready_in", int'(ready_in), 0);
      reset_n = 1'b1;
      #1 chk("rel_ready_in_pre", int'(ready_in), 0);
      @(negedge clk);
      chk("rel_ready_in", int'(ready_in), 1);

      // impulse with a 5-cycle stall in OUT_A of sample 3
      for (int n = 0; n < 16; n++) begin
         x = (n == 0) ? 16384 : 0;
         do_sample(x, (n == 3) ? 5 : 0, exp_imp[n], ye, yo, lat);
         chk("imp_even", ye, exp_imp[n]);
         chk("imp_odd", yo, (n == 7) ? 16384 : 0);
         if (n == 0) chk("latency", lat, 17);
      end

      // DC 1000: flat response once the delay line is full
      for (int n = 0; n < 40; n++) begin
         do_sample(1000, 0, 0, ye, yo, lat);
         if (n >= 15) begin
            chk("dc_even", ye, 1000);
            chk("dc_odd", yo, 1000);
         end
      end

      // sign-matched full-scale pattern, then its negation
      for (int m = 0; m < 32; m++) begin
         if (m < 16) x = (tap_sgn[m] > 0) ? 32767 : -32768;
         else        x = (tap_sgn[m-16] > 0) ? -32768 : 32767;
         do_sample(x, 0, 0, ye, yo, lat);
         if (m == 15) begin
`ifdef HB_INTERP_SATURATE_EN
            chk("ovf_pos_even", ye, 32767);
`else
            chk("ovf_pos_even", ye, -449);
`endif
            chk("ovf_pos_odd", yo, 32767);
         end
         if (m == 31) begin
`ifdef HB_INTERP_SATURATE_EN
            chk("ovf_neg_even", ye, -32768);
`else
            chk("ovf_neg_even", ye, 448);
`endif
            chk("ovf_neg_odd", yo, -32768);
         end
      end

      // reset asserted during MAC cycle 8
      data_in  = 16'sd16384;
      valid_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid_in = 1'b0;
      repeat (7) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid_out", int'(valid_out), 0);
      chk("mid_rst_data_out", int'(data_out), 0);
      chk("mid_rst_ready_in", int'(ready_in), 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      #1 chk("mid_rel_ready_in_pre", int'(ready_in), 0);
      @(negedge clk);
      chk("mid_rel_ready_in", int'(ready_in), 1);
      chk("mid_rel_valid_out", int'(valid_out), 0);
      do_sample(0, 0, 0, ye, yo, lat);
      chk("post_rst_even", ye, 0);
      chk("post_rst_odd", yo, 0);
      for (int n = 0; n < 16; n++) begin
         x = (n == 0) ? 16384 : 0;
         do_sample(x, 0, 0, ye, yo, lat);
         chk("imp2_even", ye, exp_imp[n]);
         chk("imp2_odd", yo, (n == 7) ? 16384 : 0);
      end

      // throughput with valid_in held high
      data_in  = '0;
      valid_in = 1'b1;
      begin
         int w;
         w = 0;
         while (!ready_in && w < 40) begin @(negedge clk); w++; end
         if (!ready_in) chk("thr_first_wait", int'(ready_in), 1);
      end
      @(posedge clk);
      acc_cnt  = 0;
      out_cnt  = 0;
      last_acc = 0;
      for (int i = 1; i <= 190; i++) begin
         @(negedge clk);
         a_nxt = valid_in & ready_in;
         h_nxt = valid_out & ready_out;
         @(posedge clk);
         if (a_nxt) begin
            acc_cnt++;
            chk("thr_gap", i - last_acc, 19);
            last_acc = i;
         end
         if (h_nxt) out_cnt++;
      end
      @(negedge clk);
      valid_in = 1'b0;
      chk("thr_accepts", acc_cnt, 10);
      chk("thr_outputs", out_cnt, 20);
      repeat (25) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
